// File: rtl/turfio_ctl_pkg.sv
// Shared definitions for the TURFIO ctl_ Wishbone master: FSM states,
// command header field positions and the default error read word.
package turfio_ctl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GETDATA = 2'd1,
    WBCYC   = 2'd2,
    RESP    = 2'd3
  } ctl_state_t;

  // Command header layout: [31]=we, [30:26] ignored, [25:22] sel, [21:0] byte address
  localparam int HDR_WE_BIT   = 31;
  localparam int HDR_SEL_MSB  = 25;
  localparam int HDR_SEL_LSB  = 22;
  localparam int HDR_ADR_MSB  = 21;

  // Bit set in an echoed write header when the cycle failed
  localparam int ERR_FLAG_BIT = 30;

  localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEADBEEF;

  // Extract the 4-bit byte select from a header word
  function automatic logic [3:0] hdr_sel(input logic [31:0] hdr);
    return hdr[HDR_SEL_MSB:HDR_SEL_LSB];
  endfunction

endpackage

// File: rtl/turfio_ctl_timeout.sv
// Wait-cycle counter for the Wishbone cycle: cleared by load, advances only
// while enabled, and flags the TIMEOUT-th enabled cycle as expired.
module turfio_ctl_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // expired marks the TIMEOUT-th cycle spent in the Wishbone cycle
  assign expired = count_en && (cnt == LAST);

  // Clear on entry to the cycle, then count each waiting cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/turfio_ctl_wbm.sv
// Wishbone master for the TURFIO ctl_ slot: converts command words from the
// CIN path into single WB cycles and returns one response word per command.
module turfio_ctl_wbm
  import turfio_ctl_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH = 22,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    TIMEOUT       = 1023,
  parameter logic [DATA_WIDTH-1:0] ERR_WORD      = ERR_WORD_DEFAULT
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  input  logic [DATA_WIDTH-1:0]    cmd_dat_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  output logic [DATA_WIDTH-1:0]    rsp_dat_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic                     cyc_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [ADDRESS_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0]    dat_o,
  output logic [3:0]               sel_o,
  input  logic [DATA_WIDTH-1:0]    dat_i,
  input  logic                     ack_i,
  input  logic                     err_i,
  input  logic                     rty_i,
  output logic [15:0]              err_count_o
);

  ctl_state_t            state;
  logic [1:0]            rst_sync;
  logic                  rst_n;
  logic [DATA_WIDTH-1:0] hdr_q;
  logic                  cmd_accept;
  logic                  start_cyc;
  logic                  expired;

  // Saturating increment for the failure counter
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Header echo with the failure flag forced to the given value
  function automatic logic [DATA_WIDTH-1:0] with_err_flag(input logic [DATA_WIDTH-1:0] h,
                                                          input logic                  f);
    logic [DATA_WIDTH-1:0] r;
    r               = h;
    r[ERR_FLAG_BIT] = f;
    return r;
  endfunction

  // Reset asserts immediately and releases on a clock edge
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign cmd_accept = cmd_valid_i && cmd_ready_o;
  // The last command word of a transaction launches the bus cycle
  assign start_cyc  = cmd_accept &&
                      ((state == GETDATA) || ((state == IDLE) && !cmd_dat_i[HDR_WE_BIT]));

  turfio_ctl_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (wb_clk_i),
    .rst_n    (rst_n),
    .load     (start_cyc),
    .count_en (state == WBCYC),
    .expired  (expired)
  );

  // Command / bus / response sequencer with registered outputs
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
      we_o        <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= 4'h0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      err_count_o <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_o <= 1'b1;
          if (cmd_accept) begin
            hdr_q <= cmd_dat_i;
            we_o  <= cmd_dat_i[HDR_WE_BIT];
            sel_o <= hdr_sel(cmd_dat_i);
            adr_o <= {cmd_dat_i[ADDRESS_WIDTH-1:2], 2'b00};
            if (cmd_dat_i[HDR_WE_BIT]) begin
              state <= GETDATA;
            end else begin
              cmd_ready_o <= 1'b0;
              cyc_o       <= 1'b1;
              stb_o       <= 1'b1;
              state       <= WBCYC;
            end
          end
        end
        GETDATA: begin
          if (cmd_accept) begin
            dat_o       <= cmd_dat_i;
            cmd_ready_o <= 1'b0;
            cyc_o       <= 1'b1;
            stb_o       <= 1'b1;
            state       <= WBCYC;
          end
        end
        WBCYC: begin
          // ack takes priority over a simultaneous err/rty
          if (ack_i) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= we_o ? with_err_flag(hdr_q, 1'b0) : dat_i;
            state       <= RESP;
          end else if (err_i || rty_i || expired) begin
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= we_o ? with_err_flag(hdr_q, 1'b1) : ERR_WORD;
            err_count_o <= sat_inc(err_count_o);
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_turfio_ctl_wbm.sv
// Scoreboard bench for turfio_ctl_wbm: directed commands push their expected
// response words; a monitor pops and compares at each response handshake.
module tb_turfio_ctl_wbm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cmd_dat = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] rsp_dat;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        cyc, stb, we;
  logic [21:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic [31:0] rdat;
  logic        ack, err, rty;
  logic [15:0] err_count;

  // slave model controls
  localparam int M_ACK = 0, M_ERR = 1, M_RTY = 2, M_NONE = 3, M_ACKERR = 4;
  int          s_mode  = M_ACK;
  int          s_delay = 0;
  logic [31:0] s_rdata = '0;
  int          wcnt    = 0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];

  // cycle-shape monitor state
  int          cur_len = 0;
  int          last_len = 0;
  int          pulses = 0;
  logic [21:0] cap_adr;
  logic [31:0] cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we;

  bit ok_a, ok_b;

  always #5 clk = ~clk;

  turfio_ctl_wbm dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cmd_dat_i   (cmd_dat),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .cyc_o       (cyc),
    .stb_o       (stb),
    .we_o        (we),
    .adr_o       (adr),
    .dat_o       (wdat),
    .sel_o       (sel),
    .dat_i       (rdat),
    .ack_i       (ack),
    .err_i       (err),
    .rty_i       (rty),
    .err_count_o (err_count)
  );

  wire active = cyc && stb && (wcnt >= s_delay);
  assign ack  = active && ((s_mode == M_ACK) || (s_mode == M_ACKERR));
  assign err  = active && ((s_mode == M_ERR) || (s_mode == M_ACKERR));
  assign rty  = active && (s_mode == M_RTY);
  assign rdat = s_rdata ^ {10'b0, adr};

  always @(posedge clk) begin
    if (cyc && stb && !(ack || err || rty)) wcnt <= wcnt + 1;
    else                                    wcnt <= 0;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endfunction

  // response scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rsp_unexpected: got %h expected none", rsp_dat);
      end else begin
        check("rsp", rsp_dat, exp_q.pop_front());
      end
    end
  end

  // bus cycle shape monitor
  always @(negedge clk) begin
    if (cyc) begin
      cur_len = cur_len + 1;
      cap_adr = adr;
      cap_dat = wdat;
      cap_sel = sel;
      cap_we  = we;
    end else if (cur_len != 0) begin
      last_len = cur_len;
      pulses   = pulses + 1;
      cur_len  = 0;
    end
  end

  task automatic send_word(input logic [31:0] w, output bit ok);
    int b = 0;
    cmd_dat   = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    ok = cmd_ready;
    if (!cmd_ready) bound_fail("cmd_accept");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((exp_q.size() != 0 || cyc || rsp_valid) && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    if (b >= 2000) bound_fail("wait_idle");
    @(posedge clk); #1;
  endtask

  task automatic slave(input int mode, input int delay, input logic [31:0] data);
    s_mode  = mode;
    s_delay = delay;
    s_rdata = data;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  p0;
    bit  ok, bad;
    logic [31:0] held;
    int  b;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_adr", 32'(adr), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst_n = 1'b1;

    // read 0x000000, ack after 2 wait cycles
    slave(M_ACK, 2, 32'h54464941);
    p0 = pulses;
    exp_q.push_back(32'h54464941);
    send_word(32'h00000000, ok);
    wait_idle();
    check("rd_pulses", 32'(pulses - p0), 32'd1);
    check("rd_len", 32'(last_len), 32'd3);
    check("rd_we", 32'(cap_we), 32'd0);
    check("rd_sel", 32'(cap_sel), 32'h0);

    // single-cycle ack latency
    slave(M_ACK, 0, 32'hA5A50001);
    exp_q.push_back(32'hA5A50011);
    send_word(32'h00000010, ok);
    check("lat_cyc_n1", 32'(cyc), 32'd1);
    check("lat_adr", 32'(adr), 32'h10);
    @(posedge clk); #1;
    check("lat_rsp_n2", 32'(rsp_valid), 32'd1);
    check("lat_cyc_drop", 32'(cyc), 32'd0);
    wait_idle();

    // write with ack
    slave(M_ACK, 1, 32'h0);
    exp_q.push_back(32'h83C01004);
    send_word(32'h83C01004, ok);
    send_word(32'h12345678, ok);
    wait_idle();
    check("wr_adr", 32'(cap_adr), 32'h001004);
    check("wr_sel", 32'(cap_sel), 32'hF);
    check("wr_dat", cap_dat, 32'h12345678);
    check("wr_we", 32'(cap_we), 32'd1);

    // read with no slave response times out
    slave(M_NONE, 0, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'h00000004, ok);
    wait_idle();
    check("to_len", 32'(last_len), 32'd1023);
    check("to_err_count", 32'(err_count), 32'd1);

    // write terminated by err
    slave(M_ERR, 1, 32'h0);
    exp_q.push_back(32'hC0000020);
    send_word(32'h80000020, ok);
    send_word(32'hCAFEF00D, ok);
    wait_idle();
    check("werr_count", 32'(err_count), 32'd2);

    // read terminated by rty
    slave(M_RTY, 0, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    send_word(32'h00000030, ok);
    wait_idle();
    check("rty_count", 32'(err_count), 32'd3);

    // ack and err together: ack wins
    slave(M_ACKERR, 0, 32'h600DF00D);
    exp_q.push_back(32'h600DF05D);
    send_word(32'h00000050, ok);
    wait_idle();
    check("ackerr_count", 32'(err_count), 32'd3);

    // back-pressure with two reads queued
    slave(M_ACK, 0, 32'h0F0F0000);
    rsp_ready = 1'b0;
    p0 = pulses;
    exp_q.push_back(32'h0F0F0100);
    exp_q.push_back(32'h0F0F0200);
    fork
      begin
        send_word(32'h00000100, ok_a);
        send_word(32'h00000200, ok_b);
      end
      begin
        b = 0;
        while (!rsp_valid && b < 100) begin
          @(posedge clk); #1;
          b++;
        end
        if (!rsp_valid) bound_fail("bp_rsp_valid");
        held = rsp_dat;
        bad  = 1'b0;
        repeat (50) begin
          @(posedge clk); #1;
          if (cmd_ready || !rsp_valid || rsp_dat !== held) bad = 1'b1;
        end
        check("bp_hold", 32'(bad), 32'd0);
        check("bp_held_word", held, 32'h0F0F0100);
        check("bp_one_cycle", 32'(pulses - p0), 32'd1);
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_second_cycle", 32'(pulses - p0), 32'd2);

    // saturation from a preloaded counter
    force dut.err_count_o = 16'hFFFD;
    @(posedge clk); #1;
    release dut.err_count_o;
    slave(M_NONE, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'hDEADBEEF);
      send_word(32'h00000008, ok);
      wait_idle();
      check("sat_count", 32'(err_count), (i == 0) ? 32'h0000FFFE : 32'h0000FFFF);
    end

    // reset in the middle of a bus cycle
    slave(M_NONE, 0, 32'h0);
    send_word(32'h0000000C, ok);
    repeat (5) @(posedge clk);
    #3;
    check("mid_cyc_before", 32'(cyc), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(cyc), 32'd0);
    check("mid_rst_stb", 32'(stb), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_err_count", 32'(err_count), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);

    // normal operation after reset
    slave(M_ACK, 1, 32'h13572468);
    exp_q.push_back(32'h13572428);
    send_word(32'h00000040, ok);
    wait_idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
